slow_clock_meter: RTL and testbench

Measures an externally supplied slow periodic signal (e.g. the output of a clock divider, or a board-level clock) in units of `fastclock` cycles. The block synchronises the input, detects edges, and reports period and high time once per input cycle with a one-cycle valid strobe. It also flags a stalled input via a timeout. It is the observing end of the clock-divider path, used for self-check and calibration of divider outputs.

---
 rtl/slow_clock_meter.sv | 122 ++++++++++++
 tb/tb_slow_clock_meter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slow_clock_meter.sv
// Measures period and high time of an asynchronous slow input in fastclock cycles,
// with a one-cycle valid strobe per input cycle and a stall timeout.
module slow_clock_meter #(
  parameter int              WIDTH   = 20,
  parameter logic [WIDTH-1:0] TIMEOUT = 20'hFFFFF
) (
  input  logic             fastclock,
  input  logic             reset,
  input  logic             slowclock_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             stalled
);

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    LOCKED
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             s1, s2, s3;
  logic             rise, fall;
  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] hi_lat_reg;
  state_t           state_reg, state_next;
  logic [WIDTH-1:0] period_reg, period_next;
  logic [WIDTH-1:0] high_reg, high_next;
  logic             valid_reg, valid_next;
  logic             locked_reg, locked_next;
  logic             stalled_reg, stalled_next;

  // Chain resets high so an input held high across reset release is not seen as a rise.
  always_ff @(posedge fastclock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= slowclock_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_ff @(posedge fastclock or posedge reset) begin
    if (reset) begin
      cnt_reg    <= '0;
      hi_lat_reg <= '0;
    end else begin
      if (rise)
        cnt_reg <= ONE;
      else if (cnt_reg != TIMEOUT)
        cnt_reg <= cnt_reg + ONE;
      if (fall)
        hi_lat_reg <= cnt_reg;
    end
  end

  always_ff @(posedge fastclock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      period_reg  <= '0;
      high_reg    <= '0;
      valid_reg   <= 1'b0;
      locked_reg  <= 1'b0;
      stalled_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      period_reg  <= period_next;
      high_reg    <= high_next;
      valid_reg   <= valid_next;
      locked_reg  <= locked_next;
      stalled_reg <= stalled_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    period_next  = period_reg;
    high_next    = high_reg;
    valid_next   = 1'b0;
    locked_next  = locked_reg;
    stalled_next = stalled_reg;
    case (state_reg)
      IDLE: begin
        if (rise) begin
          state_next   = FIRST;
          stalled_next = 1'b0;
        end
      end
      FIRST, LOCKED: begin
        // A rise coinciding with a saturated counter is a legal maximum-period measurement.
        if (rise) begin
          state_next  = LOCKED;
          period_next = cnt_reg;
          high_next   = hi_lat_reg;
          valid_next  = 1'b1;
          locked_next = 1'b1;
        end else if (cnt_reg == TIMEOUT) begin
          state_next   = IDLE;
          stalled_next = 1'b1;
          locked_next  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign period    = period_reg;
  assign high_time = high_reg;
  assign valid     = valid_reg;
  assign locked    = locked_reg;
  assign stalled   = stalled_reg;

endmodule

// File: tb/tb_slow_clock_meter.sv
// Directed bench for slow_clock_meter: expected measurements are queued by the
// stimulus and checked by an independent monitor on each valid strobe.
module tb_slow_clock_meter;

  localparam int W = 20;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         slow = 1'b0;
  logic         sel = 1'b0;
  logic         slow50, slow30;
  logic [W-1:0] period50, high50, period30, high30;
  logic         valid50, locked50, stalled50, valid30, locked30, stalled30;
  logic [W-1:0] mon_period, mon_high;
  logic         mon_valid, mon_locked, mon_stalled;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int last_valid_cycle = 0;

  typedef struct {
    int per;
    int hi;
    int gap;
  } exp_t;
  exp_t exp_q[$];

  int have_prev = 0;
  int first_meas = 1;
  int prev_h = 0;
  int prev_l = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  assign slow50 = sel ? 1'b0 : slow;
  assign slow30 = sel ? slow : 1'b0;

  slow_clock_meter #(.WIDTH(W), .TIMEOUT(20'd50)) dut50 (
    .fastclock(clk), .reset(reset), .slowclock_in(slow50),
    .period(period50), .high_time(high50), .valid(valid50),
    .locked(locked50), .stalled(stalled50)
  );

  slow_clock_meter #(.WIDTH(W), .TIMEOUT(20'd30)) dut30 (
    .fastclock(clk), .reset(reset), .slowclock_in(slow30),
    .period(period30), .high_time(high30), .valid(valid30),
    .locked(locked30), .stalled(stalled30)
  );

  assign mon_period  = sel ? period30 : period50;
  assign mon_high    = sel ? high30 : high50;
  assign mon_valid   = sel ? valid30 : valid50;
  assign mon_locked  = sel ? locked30 : locked50;
  assign mon_stalled = sel ? stalled30 : stalled50;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Monitor: one line per measurement.
  always @(negedge clk) begin
    if (!reset && mon_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got period=%0d high=%0d expected no valid (cycle %0d)",
                 mon_period, mon_high, cycle);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("valid: period=%0d high_time=%0d (expect %0d/%0d) cycle %0d",
                 mon_period, mon_high, e.per, e.hi, cycle);
        check("period", int'(mon_period), e.per);
        check("high_time", int'(mon_high), e.hi);
        check("locked_at_valid", int'(mon_locked), 1);
        check("stalled_at_valid", int'(mon_stalled), 0);
        if (e.gap != 0) check("valid_spacing", cycle - last_valid_cycle, e.gap);
      end
      last_valid_cycle = cycle;
    end
  end

  task automatic restart();
    have_prev  = 0;
    first_meas = 1;
  endtask

  task automatic push_prev();
    if (have_prev != 0) begin
      exp_q.push_back('{prev_h + prev_l, prev_h, (first_meas != 0) ? 0 : prev_h + prev_l});
      first_meas = 0;
    end
  endtask

  // One input period: high for h cycles, low for l cycles.
  task automatic send(input int h, input int l);
    push_prev();
    slow = 1'b1;
    repeat (h) @(posedge clk);
    #1;
    slow = 1'b0;
    repeat (l) @(posedge clk);
    #1;
    prev_h    = h;
    prev_l    = l;
    have_prev = 1;
  endtask

  // Final rise closing the last period; leaves the input high.
  task automatic close();
    push_prev();
    slow      = 1'b1;
    have_prev = 0;
    repeat (6) @(posedge clk);
    #1;
    check("drained", exp_q.size(), 0);
  endtask

  task automatic do_reset(input logic new_sel, input logic level);
    @(posedge clk);
    #3;
    reset = 1'b1;
    sel   = new_sel;
    slow  = level;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    restart();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;

    // Reset state
    #2;
    check("rst_period", int'(period50), 0);
    check("rst_high", int'(high50), 0);
    check("rst_valid", int'(valid50), 0);
    check("rst_locked", int'(locked50), 0);
    check("rst_stalled", int'(stalled50), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Divider MAX_COUNT=9: 10-cycle period, high 5
    restart();
    for (int i = 0; i < 6; i++) send(5, 5);
    close();
    check("locked_t1", int'(locked50), 1);

    // Input high through reset release, low 7, then 12/4
    do_reset(1'b0, 1'b1);
    slow = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(4, 8);
    close();

    // Stall at TIMEOUT=50 after locking on a 20-cycle clock
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send(10, 10);
    restart();
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(negedge clk);
      if (stalled50) seen = 1;
    end
    check("stall_seen", seen, 1);
    check("stall_delay", cycle - last_valid_cycle, 50);
    check("stall_locked", int'(locked50), 0);
    check("stall_period_hold", int'(period50), 20);
    check("stall_high_hold", int'(high50), 10);
    @(posedge clk);
    #1;
    send(10, 10);
    check("unstall_stalled", int'(stalled50), 0);
    check("unstall_first_locked", int'(locked50), 0);
    send(10, 10);
    close();
    check("relock", int'(locked50), 1);

    // TIMEOUT=30 with a period of exactly 30: rise wins
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send(10, 20);
    close();
    check("t30_stalled", int'(stalled30), 0);
    check("t30_locked", int'(locked30), 1);

    // Asynchronous reset mid high phase while locked
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send(8, 8);
    close();
    check("pre_reset_locked", int'(locked50), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_period", int'(period50), 0);
    check("async_high", int'(high50), 0);
    check("async_valid", int'(valid50), 0);
    check("async_locked", int'(locked50), 0);
    check("async_stalled", int'(stalled50), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    restart();
    repeat (3) @(posedge clk);
    #1;
    slow = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(6, 6);
    close();

    // Duty change between consecutive 16-cycle periods
    do_reset(1'b0, 1'b0);
    send(3, 13);
    send(8, 8);
    send(3, 13);
    close();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
